// File: rtl/counter_host.sv
// counter_host: host-side sequencer for the programmable up/down counter.
// Optionally loads a start value over the shared bus, issues a number of
// count pulses, reads the counter back and compares it with a shadow copy.
// Optional feature macro: CNT_HOST_ERRCNT_EN enables the saturating
// mismatch counter on err_count; otherwise err_count is tied to zero.
module counter_host #(
    parameter int WIDTH    = 8,
    parameter int PULSE_HI = 2,
    parameter int PULSE_LO = 2,
    parameter int SETTLE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_do_load,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic [WIDTH-1:0] cmd_pulses,
    input  logic             cmd_up_down,
    output logic             cnt_enable,
    output logic             cnt_clk_in,
    output logic             cnt_load,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_in,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_count,
    output logic [WIDTH-1:0] rsp_expected,
    output logic             rsp_match,
    output logic [7:0]       err_count
);

    typedef enum logic [3:0] {
        IDLE,
        LD_SETUP,
        LD_DRIVE,
        LD_HI,
        LD_LO,
        LD_RELEASE,
        CNT_HI,
        CNT_LO,
        SETTLE_WAIT,
        SAMPLE,
        RESP
    } state_t;

    localparam logic [15:0] HI_LAST     = 16'(PULSE_HI - 1);
    localparam logic [15:0] LO_LAST     = 16'(PULSE_LO - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    state_t             state;
    state_t             next_state;
    logic [15:0]        phase_cnt;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   remaining;
    logic               dir_up;
    logic [WIDTH-1:0]   expected;
    logic               handshake;
    logic               pulse_done;

    assign handshake  = (state == IDLE) && cmd_valid;
    assign pulse_done = (state == CNT_LO) && (phase_cnt == LO_LAST);

    // Next-state decode; multi-cycle phases advance when their cycle counter hits the last cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_do_load)
                        next_state = LD_SETUP;
                    else if (cmd_pulses != '0)
                        next_state = CNT_HI;
                    else
                        next_state = SETTLE_WAIT;
                end
            end
            LD_SETUP:    next_state = LD_DRIVE;
            LD_DRIVE:    next_state = LD_HI;
            LD_HI:       if (phase_cnt == HI_LAST) next_state = LD_LO;
            LD_LO:       if (phase_cnt == LO_LAST) next_state = LD_RELEASE;
            LD_RELEASE:  next_state = (remaining != '0) ? CNT_HI : SETTLE_WAIT;
            CNT_HI:      if (phase_cnt == HI_LAST) next_state = CNT_LO;
            CNT_LO: begin
                if (phase_cnt == LO_LAST)
                    next_state = (remaining == WIDTH'(1)) ? SETTLE_WAIT : CNT_HI;
            end
            SETTLE_WAIT: if (phase_cnt == SETTLE_LAST) next_state = SAMPLE;
            SAMPLE:      next_state = RESP;
            RESP:        next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // State, command latches, expected shadow and all registered outputs (decoded from the state being entered).
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            load_val     <= '0;
            remaining    <= '0;
            dir_up       <= 1'b0;
            expected     <= '0;
            cmd_ready    <= 1'b1;
            cnt_enable   <= 1'b0;
            cnt_clk_in   <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_up_down  <= 1'b0;
            bus_out      <= '0;
            bus_oe       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_count    <= '0;
            rsp_expected <= '0;
            rsp_match    <= 1'b0;
`ifdef CNT_HOST_ERRCNT_EN
            err_count    <= '0;
`endif
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state) ? 16'd0 : phase_cnt + 16'd1;

            if (handshake) begin
                load_val    <= cmd_load_val;
                remaining   <= cmd_pulses;
                dir_up      <= cmd_up_down;
                cnt_up_down <= cmd_up_down;
            end

            if (state == LD_RELEASE)
                expected <= load_val;

            if (pulse_done) begin
                remaining <= remaining - WIDTH'(1);
                expected  <= dir_up ? expected + WIDTH'(1) : expected - WIDTH'(1);
            end

            if (state == SAMPLE) begin
                rsp_count    <= bus_in;
                rsp_expected <= expected;
                rsp_match    <= (bus_in == expected);
`ifdef CNT_HOST_ERRCNT_EN
                if ((bus_in != expected) && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
`endif
            end

            cmd_ready  <= (next_state == IDLE);
            cnt_enable <= (next_state != IDLE);
            cnt_load   <= (next_state == LD_SETUP) || (next_state == LD_DRIVE) ||
                          (next_state == LD_HI)    || (next_state == LD_LO)    ||
                          (next_state == LD_RELEASE);
            bus_oe     <= (next_state == LD_DRIVE) || (next_state == LD_HI) ||
                          (next_state == LD_LO);
            bus_out    <= ((next_state == LD_DRIVE) || (next_state == LD_HI) ||
                           (next_state == LD_LO)) ? load_val : '0;
            cnt_clk_in <= (next_state == LD_HI) || (next_state == CNT_HI);
            rsp_valid  <= (next_state == RESP);
        end
    end

`ifndef CNT_HOST_ERRCNT_EN
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_counter_host.sv
// tb_counter_host: directed bench for counter_host with a behavioural model
// of the counter on the far side of the pin interface.
module tb_counter_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_do_load;
    logic [7:0] cmd_load_val;
    logic [7:0] cmd_pulses;
    logic       cmd_up_down;
    logic       cnt_enable;
    logic       cnt_clk_in;
    logic       cnt_load;
    logic       cnt_up_down;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic       rsp_valid;
    logic [7:0] rsp_count;
    logic [7:0] rsp_expected;
    logic       rsp_match;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_val;
    logic       model_prev_clk;
    logic [7:0] corrupt_ofs = 8'd0;
    logic       inv_viol = 1'b0;

`ifdef CNT_HOST_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    counter_host dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_do_load  (cmd_do_load),
        .cmd_load_val (cmd_load_val),
        .cmd_pulses   (cmd_pulses),
        .cmd_up_down  (cmd_up_down),
        .cnt_enable   (cnt_enable),
        .cnt_clk_in   (cnt_clk_in),
        .cnt_load     (cnt_load),
        .cnt_up_down  (cnt_up_down),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .bus_in       (bus_in),
        .rsp_valid    (rsp_valid),
        .rsp_count    (rsp_count),
        .rsp_expected (rsp_expected),
        .rsp_match    (rsp_match),
        .err_count    (err_count)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Shared bus: host value while it drives, otherwise the counter's value (optionally corrupted).
    assign bus_in = bus_oe ? bus_out : model_val + corrupt_ofs;

    // Counter model: acts on each rising cnt_clk_in while enabled, load or count.
    always @(posedge clk) begin
        model_prev_clk <= cnt_clk_in;
        if (rst)
            model_val <= 8'd0;
        else if (cnt_clk_in && !model_prev_clk && cnt_enable) begin
            if (cnt_load)
                model_val <= bus_in;
            else
                model_val <= cnt_up_down ? model_val + 8'd1 : model_val - 8'd1;
        end
    end

    // Bus ownership watch: host drive is only legal while loading.
    always @(negedge clk) begin
        if (!rst && bus_oe && !(cnt_load && cnt_enable))
            inv_viol <= 1'b1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic do_load, input logic [7:0] load_val,
                                  input logic [7:0] pulses, input logic up,
                                  input logic [7:0] exp_count, input logic [7:0] exp_expected,
                                  input logic exp_match, input int exp_cycles);
        int   cyc = 0;
        int   pulses_seen = 0;
        logic prev_clk = 1'b0;
        logic ready_bad = 1'b0;
        logic dir_bad = 1'b0;
        logic done = 1'b0;
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_do_load  = do_load;
        cmd_load_val = load_val;
        cmd_pulses   = pulses;
        cmd_up_down  = up;
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_do_load  = ~do_load;
        cmd_load_val = ~load_val;
        cmd_pulses   = pulses + 8'd3;
        cmd_up_down  = ~up;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cmd_ready) ready_bad = 1'b1;
            if (cnt_up_down !== up) dir_bad = 1'b1;
            if (cnt_clk_in && !prev_clk && !cnt_load) pulses_seen++;
            prev_clk = cnt_clk_in;
            if (rsp_valid) begin
                done = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = cyc[0];
            end
        end
        cmd_valid = 1'b0;
        check_output({tag, ".resp_seen"}, 32'(done), 32'd1);
        check_output({tag, ".resp_cycle"}, 32'(cyc), 32'(exp_cycles));
        check_output({tag, ".rsp_count"}, 32'(rsp_count), 32'(exp_count));
        check_output({tag, ".rsp_expected"}, 32'(rsp_expected), 32'(exp_expected));
        check_output({tag, ".rsp_match"}, 32'(rsp_match), 32'(exp_match));
        check_output({tag, ".count_pulses"}, 32'(pulses_seen), 32'(pulses));
        check_output({tag, ".ready_while_busy"}, 32'(ready_bad), 32'd0);
        check_output({tag, ".dir_held"}, 32'(dir_bad), 32'd0);
        @(negedge clk);
        check_output({tag, ".strobe_one_cycle"}, 32'(rsp_valid), 32'd0);
        check_output({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
        check_output({tag, ".count_held"}, 32'(rsp_count), 32'(exp_count));
    endtask

    // Directed sequence: reset state, load/count/readback cases, mismatches, mid-transaction reset.
    initial begin
        int wait_cyc;
        int rsp_seen;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_do_load  = 1'b0;
        cmd_load_val = 8'd0;
        cmd_pulses   = 8'd0;
        cmd_up_down  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("reset.outputs", {cnt_enable, cnt_clk_in, cnt_load, cnt_up_down, bus_oe, rsp_valid, rsp_match},
                     32'd0);
        check_output("reset.bus_out", 32'(bus_out), 32'd0);
        check_output("reset.rsp_count", 32'(rsp_count), 32'd0);
        check_output("reset.err_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Load 0x10, three pulses up: RESP lands in the 23rd cycle after the handshake edge.
        apply_stimulus("load_up", 1'b1, 8'h10, 8'd3, 1'b1, 8'h13, 8'h13, 1'b1, 23);

        // Load 0x01, count down twice through zero, then one more without loading.
        apply_stimulus("load_down_wrap", 1'b1, 8'h01, 8'd2, 1'b0, 8'hFF, 8'hFF, 1'b1, 19);
        apply_stimulus("noload_down", 1'b0, 8'h77, 8'd1, 1'b0, 8'hFE, 8'hFE, 1'b1, 8);

        // Load with zero pulses: load phases, settle, sample, respond.
        apply_stimulus("load_zero", 1'b1, 8'h00, 8'd0, 1'b1, 8'h00, 8'h00, 1'b1, 11);

        // Counter reads back one higher than the shadow.
        corrupt_ofs = 8'd1;
        apply_stimulus("mismatch", 1'b1, 8'h50, 8'd4, 1'b1, 8'h55, 8'h54, 1'b0, 27);
        check_output("err_count.first", 32'(err_count), ERRCNT_ON ? 32'd1 : 32'd0);
        for (int i = 0; i < 299; i++)
            apply_stimulus("mismatch_rep", 1'b0, 8'h00, 8'd0, 1'b1, 8'h55, 8'h54, 1'b0, 4);
        check_output("err_count.saturated", 32'(err_count), ERRCNT_ON ? 32'd255 : 32'd0);
        corrupt_ofs = 8'd0;

        // Five-pulse command aborted by reset during a count-high phase.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_do_load = 1'b0;
        cmd_pulses  = 8'd5;
        cmd_up_down = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_cyc = 0;
        @(negedge clk);
        while (!(cnt_clk_in && !cnt_load) && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_output("abort.reached_cnt_hi", 32'(cnt_clk_in && !cnt_load), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("abort.cnt_clk_in", 32'(cnt_clk_in), 32'd0);
        check_output("abort.bus_oe", 32'(bus_oe), 32'd0);
        check_output("abort.cnt_enable", 32'(cnt_enable), 32'd0);
        check_output("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("abort.err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        rsp_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check_output("abort.no_response", 32'(rsp_seen), 32'd0);
        apply_stimulus("post_reset", 1'b0, 8'h00, 8'd0, 1'b1, 8'h00, 8'h00, 1'b1, 4);

        check_output("bus_oe_invariant", 32'(inv_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/counter_host.md
Name: counter_host

Overview:
- Sequencer that programs and exercises the team's programmable up/down counter over its pin-level interface: enable, external count clock, load, up/down, and the shared 8-bit bidirectional value bus.
- Optionally loads a start value, issues N count pulses in the chosen direction, then reads the counter's value back and compares it with an internally tracked expected value.
- Sits on the host/test side of the chip-to-chip counter interface, opposite the counter block.

Parameters:
- WIDTH, 8, width of value bus, load value, pulse count and expected value.
- PULSE_HI, 2, clk cycles cnt_clk_in is held high per pulse (≥1).
- PULSE_LO, 2, clk cycles cnt_clk_in is held low per pulse (≥1).
- SETTLE, 2, clk cycles waited before sampling bus_in (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; handshake occurs on cmd_valid&cmd_ready
- cmd_do_load  input  1  perform load phase
- cmd_load_val  input  WIDTH  value to load
- cmd_pulses  input  WIDTH  number of count pulses (0 allowed)
- cmd_up_down  input  1  1=count up, 0=count down
- cnt_enable  output  1  counter enable
- cnt_clk_in  output  1  counter count/load clock
- cnt_load  output  1  counter load select
- cnt_up_down  output  1  counter direction
- bus_out  output  WIDTH  value driven onto shared bus
- bus_oe  output  1  host bus drive enable
- bus_in  input  WIDTH  shared bus readback
- rsp_valid  output  1  one-cycle response strobe
- rsp_count  output  WIDTH  sampled counter value
- rsp_expected  output  WIDTH  expected value
- rsp_match  output  1  rsp_count == rsp_expected
- err_count  output  8  mismatch counter (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; expected shadow=0, matching the counter's post-reset value. Reset mid-transaction aborts it immediately, drops bus_oe, cnt_clk_in and cnt_load, and emits no response.
- Command fields are latched at handshake; later input changes are ignored.
- cnt_up_down = latched direction, driven from the handshake onward and held through the response cycle.
- States and durations:
  - IDLE: cnt_enable=0. Goes to LD_SETUP if cmd_do_load, otherwise to CNT_HI if pulses>0, otherwise to SETTLE.
  - LD_SETUP (1): cnt_enable=1, cnt_load=1, bus_oe=0. The counter releases the bus before the host drives it.
  - LD_DRIVE (1): bus_oe=1, bus_out=load_val.
  - LD_HI (PULSE_HI): cnt_clk_in=1, with bus still driven.
  - LD_LO (PULSE_LO): cnt_clk_in=0, with bus still driven.
  - LD_RELEASE (1): bus_oe=0, cnt_load still 1. Load is released one cycle after the bus is released, so there is never contention.
  - After LD_RELEASE: expected=load_val, then go to CNT_HI if pulses>0, otherwise to SETTLE.
  - CNT_HI (PULSE_HI) / CNT_LO (PULSE_LO): cnt_enable=1, cnt_load=0. Each completed LO phase decrements the remaining count and updates expected ±1 mod 2^WIDTH (wraps 0xFF→0x00 up, 0x00→0xFF down). Loop until remaining=0.
  - SETTLE (SETTLE): cnt_enable=1, cnt_load=0; the counter drives the bus.
  - SAMPLE (1): rsp_count<=bus_in.
  - RESP (1): rsp_valid=1, rsp_match updated, then return to IDLE. rsp_count, rsp_expected and rsp_match hold until the next RESP.
- Invariant: bus_oe=1 only while cnt_load=1 and cnt_enable=1.
- Expected shadow persists across commands. A command with cmd_do_load=0 continues counting from the previous expected value.

Optional Feature:
- Macro: CNT_HOST_ERRCNT_EN.
- Defined: err_count increments in each RESP cycle where rsp_match=0, saturates at 0xFF, and is cleared only by rst.
- Undefined: err_count is tied to 0 and no counter logic is present.

Test Plan:
- Load 0x10, 3 pulses, up; bench counter model returns 0x13 → with default parameters rsp_valid is high exactly 23 cycles after the handshake edge; rsp_count=0x13, rsp_expected=0x13, rsp_match=1.
- Load 0x01, 2 pulses, down; then a no-load command with 1 pulse, down → expected 0xFF then 0xFE (wrap); both responses have rsp_match=1.
- Load 0x00, 0 pulses → response after LD phases plus SETTLE plus SAMPLE, with no CNT pulses; rsp_expected=0x00.
- Model returns 0x55 while 0x54 is expected → rsp_match=0. With CNT_HOST_ERRCNT_EN, err_count 0→1; 300 such mismatches saturate it at 0xFF. Without the macro, err_count stays 0.
- rst asserted during CNT_HI of a 5-pulse command → next cycle state is IDLE, cnt_clk_in=0, bus_oe=0, no rsp_valid, expected=0.
- Assertion over all tests: bus_oe never high unless cnt_load is high; cmd_ready is low throughout every transaction; cmd_valid pulses while busy are ignored.
